// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - readback decoder for a multiplexed active-low 7-segment display
//
// Purpose:
//   Samples the digit-select, segment and decimal-point lines of a multiplexed
//   display. Waits until each digit has been stable for STABLE_CYCLES samples,
//   then decodes the segment pattern back to its 4-bit code. Tracks complete
//   frames and declares the scan lost after TIMEOUT_CYCLES without a capture.
//
// Optional feature:
//   SEG_DP_CAPTURE_EN - when defined, dp_i is synchronised, is part of the
//   stability comparison and is captured into dp_o. When undefined, dp_i is
//   ignored and dp_o is tied to 4'b0000.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   segments_i     active-low segments, bit6=a .. bit0=g
//   displays_i     active-low digit selects, bit n low = digit n lit
//   dp_i           active-low decimal point
//   sign0_o..3_o   recovered digit codes
//   digit_valid_o  bit n = sign n holds a decoded value from the current scan
//   dp_o           bit n = dp was lit when digit n was last accepted
//   frame_o        one-cycle pulse when all four digits have been captured
//   code_err_o     one-cycle pulse when an unrecognised pattern is accepted
//   timeout_o      high while the scan is lost

module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2047
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] segments_i,
  input  logic [3:0] displays_i,
  input  logic       dp_i,
  output logic [3:0] sign0_o,
  output logic [3:0] sign1_o,
  output logic [3:0] sign2_o,
  output logic [3:0] sign3_o,
  output logic [3:0] digit_valid_o,
  output logic [3:0] dp_o,
  output logic       frame_o,
  output logic       code_err_o,
  output logic       timeout_o
);

`ifdef SEG_DP_CAPTURE_EN
  localparam int VW = 12;
`else
  localparam int VW = 11;
`endif

  localparam logic [3:0]  STAB = 4'(STABLE_CYCLES);
  localparam logic [11:0] TMO  = 12'(TIMEOUT_CYCLES);

  // Sample vector layout: {displays, segments[, dp]}
  logic [VW-1:0] raw;
  logic [VW-1:0] sync1;
  logic [VW-1:0] sync2;
  logic [VW-1:0] prev;
  logic [VW-1:0] cap_vec;

`ifdef SEG_DP_CAPTURE_EN
  assign raw = {displays_i, segments_i, dp_i};
`else
  logic unused_dp;
  assign raw       = {displays_i, segments_i};
  assign unused_dp = dp_i;
`endif

  // ---------------------------------------------------------------------------
  // Synchroniser and stability filter
  // ---------------------------------------------------------------------------
  logic [3:0] stab_cnt;
  logic [3:0] stab_nxt;
  logic       stab_reach;
  logic       cap_pend;

  always_comb begin
    stab_nxt = 4'd1;
    if (sync2 == prev) begin
      stab_nxt = (stab_cnt == STAB) ? STAB : stab_cnt + 4'd1;
    end
  end

  // Only the transition into STAB accepts, so a held pattern is taken once.
  assign stab_reach = (stab_nxt == STAB) && (stab_cnt != STAB);

  // The accepted sample is latched and processed one cycle later, giving a
  // total input-to-output latency of 2 + STABLE_CYCLES edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      stab_cnt <= 4'd0;
      cap_vec  <= '0;
      cap_pend <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      prev     <= sync2;
      stab_cnt <= stab_nxt;
      cap_pend <= stab_reach;
      if (stab_reach) begin
        cap_vec <= sync2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Select qualification and segment decode
  // ---------------------------------------------------------------------------
  logic [3:0] cap_disp;
  logic [6:0] cap_seg;
  logic [3:0] sel;
  logic       capture;

  assign cap_disp = cap_vec[VW-1 -: 4];
  assign cap_seg  = cap_vec[VW-5 -: 7];
  assign sel      = ~cap_disp;

  // Exactly one select low: blanking and multiple-low selects are dropped.
  assign capture = cap_pend && (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);

  logic [3:0] dec_code;
  logic       dec_ok;
  logic       dec_blank;

  always_comb begin
    dec_code  = 4'h0;
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    case (cap_seg)
      7'b0000001: dec_code = 4'h0;
      7'b1001111: dec_code = 4'h1;
      7'b0010010: dec_code = 4'h2;
      7'b0000110: dec_code = 4'h3;
      7'b1001100: dec_code = 4'h4;
      7'b0100100: dec_code = 4'h5;
      7'b0100000: dec_code = 4'h6;
      7'b0001111: dec_code = 4'h7;
      7'b0000000: dec_code = 4'h8;
      7'b0000100: dec_code = 4'h9;
      7'b0001000: dec_code = 4'hA;
      7'b1100000: dec_code = 4'hB;
      7'b0110001: dec_code = 4'hC;
      7'b1000010: dec_code = 4'hD;
      7'b0110000: dec_code = 4'hE;
      7'b0111000: dec_code = 4'hF;
      7'b1111111: begin
        dec_ok    = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame tracking, digit registers and scan-state machine
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    LOST = 2'd2
  } state_t;

  state_t          state;
  logic [11:0]     tcnt;
  logic [3:0]      seen;
  logic [3:0]      seen_nxt;
  logic [3:0]      valid_q;
  logic [3:0][3:0] sign_q;

  assign seen_nxt = seen | sel;

`ifdef SEG_DP_CAPTURE_EN
  logic [3:0] dp_q;
  logic       cap_dp;
  assign cap_dp = cap_vec[0];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      tcnt       <= 12'd0;
      seen       <= 4'd0;
      valid_q    <= 4'd0;
      sign_q     <= '0;
      frame_o    <= 1'b0;
      code_err_o <= 1'b0;
      timeout_o  <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
      dp_q       <= 4'd0;
`endif
    end else begin
      frame_o    <= 1'b0;
      code_err_o <= 1'b0;
      if (capture) begin
        // A capture wins over a timeout falling on the same cycle.
        state     <= SCAN;
        tcnt      <= 12'd0;
        timeout_o <= 1'b0;
        if (seen_nxt == 4'hF) begin
          frame_o <= 1'b1;
          seen    <= 4'd0;
        end else begin
          seen <= seen_nxt;
        end
        if (dec_ok) begin
          valid_q <= valid_q | sel;
          for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
              sign_q[i] <= dec_code;
`ifdef SEG_DP_CAPTURE_EN
              dp_q[i]   <= ~cap_dp;
`endif
            end
          end
        end else begin
          valid_q <= valid_q & ~sel;
          if (!dec_blank) begin
            code_err_o <= 1'b1;
          end
        end
      end else if (state != LOST) begin
        // IDLE and SCAN both time out; LOST holds the counter until a capture.
        tcnt <= tcnt + 12'd1;
        if (tcnt + 12'd1 == TMO) begin
          state     <= LOST;
          timeout_o <= 1'b1;
          valid_q   <= 4'd0;
          seen      <= 4'd0;
        end
      end
    end
  end

  assign sign0_o       = sign_q[0];
  assign sign1_o       = sign_q[1];
  assign sign2_o       = sign_q[2];
  assign sign3_o       = sign_q[3];
  assign digit_valid_o = valid_q;

`ifdef SEG_DP_CAPTURE_EN
  assign dp_o = dp_q;
`else
  assign dp_o = 4'b0000;
`endif

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side companion of the RTC multiplexed 7-segment display driver.
- Samples the active-low digit-select, segment and decimal-point lines, waits until each multiplexed digit is stable, and decodes the segment pattern back to its 4-bit code.
- Exposes the four recovered digits, a per-digit valid flag and a frame-complete strobe.
- Used for display readback and self-check in the RTC design.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical synchronised samples required before a digit is accepted (range 2..15).
- TIMEOUT_CYCLES, 2047, cycles without an accepted digit before the scan is declared lost (must be less than 4096).

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- segments_i  input  7  active-low segments; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
- displays_i  input  4  active-low digit selects; bit n low = digit n lit
- dp_i  input  1  active-low decimal point
- sign0_o, sign1_o, sign2_o, sign3_o  output  4 each  recovered digit codes 0x0..0xF
- digit_valid_o  output  4  bit n = sign n holds a decoded value from the current scan
- dp_o  output  4  bit n = dp was lit (dp_i low) when digit n was last accepted
- frame_o  output  1  one-cycle pulse when all four digits have been accepted since the last pulse
- code_err_o  output  1  one-cycle pulse when an unrecognised segment pattern is accepted
- timeout_o  output  1  level, high while the scan is lost

Behaviour:
- Reset values (asynchronous, active-low): all signN_o = 0, digit_valid_o = 0, dp_o = 0, frame_o = 0, code_err_o = 0, timeout_o = 0, state IDLE, seen mask = 0, counters = 0.
- Input path: all 12 input bits pass through a 2-flop synchroniser. The vector {displays, segments, dp} is compared with the previous synchronised sample.
- Stability counter: on a mismatch the counter loads 1; on a match it increments, saturating at STABLE_CYCLES. A sample is accepted only on the cycle the counter reaches STABLE_CYCLES, so each held pattern is accepted once.
- Latency: an input held constant from clock edge t is reflected in the outputs after edge t + 2 + STABLE_CYCLES.
- Select qualification: a sample is accepted only if exactly one bit of displays is 0. All-ones (blanking) and multiple-low selects are ignored silently; they do not count as captures and do not reset the timeout.
- Decode table (pattern -> code):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3
  - 1001100->4, 0100100->5, 0100000->6, 0001111->7
  - 0000000->8, 0000100->9, 0001000->A, 1100000->B
  - 0110001->C, 1000010->D, 0110000->E, 0111000->F
- Pattern 1111111 (blank): digit_valid[n] is cleared, signN_o is kept, no error is raised, and the capture counts for frame and timeout purposes.
- Any other pattern: code_err_o pulses, digit_valid[n] is cleared, signN_o is kept, and the capture counts for frame and timeout purposes.
- Valid pattern: signN_o is loaded with the code, digit_valid[n] is set, and dp_o[n] is loaded with the inverse of dp.
- Frame tracking: each capture sets seen[n]. When seen becomes 1111 on a capture, frame_o pulses in the same cycle the outputs update and seen clears.
  - Repeated captures of the same digit before the others arrive are allowed; the latest value wins.
- State machine:
  - IDLE: after reset; moves to SCAN on the first capture.
  - SCAN: timeout counter clears on every capture. When the counter reaches TIMEOUT_CYCLES, move to LOST.
  - LOST: timeout_o = 1, digit_valid_o and seen are cleared, signN_o is held. The next capture moves to SCAN and timeout_o falls on that same edge.
  - The timeout counter also runs in IDLE: IDLE goes to LOST after TIMEOUT_CYCLES.
- Simultaneous events: a capture and a timeout in the same cycle resolve as a capture (the counter clears, the state stays or becomes SCAN).
- Reset mid-scan: all state returns to reset values immediately, and partial frames are discarded.

Optional Feature:
- Macro: SEG_DP_CAPTURE_EN.
- Defined: dp_i is synchronised, included in the stability comparison, and captured into dp_o as described above.
- Undefined: dp_i is ignored (not compared, not synchronised) and dp_o is tied to 4'b0000.

Test Plan:
- Drive digits 3,2,1,0 with codes 1,2,5,9, each held 201 cycles with a round-robin select -> sign0..3_o = 1,2,5,9, digit_valid_o = 1111, frame_o pulses once per full scan at latency 2 + 4 cycles after the fourth digit starts.
- Hold digit 2 with segments 1111111 -> digit_valid_o[2] = 0, no code_err_o, frame still completes after the other three digits.
- Drive segments 1010101 on digit 1 -> one code_err_o pulse, digit_valid_o[1] = 0, sign1_o keeps its previous value.
- Toggle segments every 2 cycles (glitch) with STABLE_CYCLES = 4 -> no capture, outputs unchanged; then hold 0001000 -> sign_o for that digit = 0xA.
- Stop scanning (displays = 1111) for 2047 cycles -> timeout_o = 1, digit_valid_o = 0000; resume scanning -> timeout_o clears on the first capture.
- With SEG_DP_CAPTURE_EN, dp_i low only on digit 2 -> dp_o = 0100. Without the macro -> dp_o = 0000. Assert rst_ni mid-frame -> all outputs return to 0 immediately.
